// File: rtl/sha1_wb_stream.sv
`default_nettype none
// ============================================================================
// Module   : sha1_wb_stream
// Brief    : Wishbone SHA-1 engine; FIFO-fed message words, chained multi-block
// Revision : 1.0
// ============================================================================
module sha1_wb_stream #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0040,
    parameter int          FIFO_DEPTH   = 32,
    parameter int          FIFO_AW      = 5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROUND  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam logic [31:0]        ID_VALUE   = 32'h5348_4131;
    localparam logic [31:0]        BUSY_VALUE = 32'hFFFF_FFF0;
    localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   LVL_BLOCK  = (FIFO_AW+1)'(16);
    localparam logic [FIFO_AW:0]   LVL_FULL   = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [4:0][31:0]   IV         = {32'hC3D2_E1F0, 32'h1032_5476,
                                                 32'h98BA_DCFE, 32'hEFCD_AB89,
                                                 32'h6745_2301};
    localparam logic [5:0] OFF_ID     = 6'h00;
    localparam logic [5:0] OFF_CTRL   = 6'h04;
    localparam logic [5:0] OFF_STATUS = 6'h08;
    localparam logic [5:0] OFF_MSG    = 6'h0C;
    localparam logic [5:0] OFF_IRQCLR = 6'h24;

    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [31:0]          dat_o_q, dat_o_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [5:0]           wr_off_q, wr_off_d;
    logic [31:0]          wr_dat_q, wr_dat_d;
    logic                 irq_en_q, irq_en_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic [31:0]          fifo_q [FIFO_DEPTH];
    logic [31:0]          fifo_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [31:0]          w_q [16];
    logic [31:0]          w_d [16];
    logic [4:0][31:0]     h_q, h_d;
    logic [31:0]          a_q, b_q, c_q, d_q, e_q;
    logic [31:0]          a_d, b_d, c_d, d_d, e_d;
    logic [6:0]           cnt_q, cnt_d;

    logic [31:0] off;
    logic        in_range, acc, is_busy, full, empty, push, pop, push_ok;
    logic [31:0] status, rd_data;
    logic [3:0]  j0, j2, j8, j13;
    logic [31:0] w_mix, w_t, f, k, temp;

    assign off      = wbs_adr_i - BASE_ADDRESS;
    assign in_range = (off <= 32'h24) && (off[1:0] == 2'b00);
    assign acc      = wbs_stb_i && wbs_cyc_i && !ack_q && in_range;
    assign is_busy  = (state_q != ST_IDLE);
    assign full     = (level_q == LVL_FULL);
    assign empty    = (level_q == '0);
    assign status   = {9'b0, (state_q == ST_ROUND) ? cnt_q : 7'd0, 8'(level_q),
                       2'b0, err_q, ovf_q, empty, full, done_q, is_busy};

    always_comb begin
        rd_data = '0;
        case (off[5:0])
            OFF_ID:     rd_data = ID_VALUE;
            OFF_CTRL:   rd_data = {31'b0, irq_en_q};
            OFF_STATUS: rd_data = status;
            6'h10:      rd_data = is_busy ? BUSY_VALUE : h_q[0];
            6'h14:      rd_data = is_busy ? BUSY_VALUE : h_q[1];
            6'h18:      rd_data = is_busy ? BUSY_VALUE : h_q[2];
            6'h1C:      rd_data = is_busy ? BUSY_VALUE : h_q[3];
            6'h20:      rd_data = is_busy ? BUSY_VALUE : h_q[4];
            default:    rd_data = '0;
        endcase
    end

    // Rolling schedule: slot j holds W[t-16]; t-3, t-8, t-14 map to j+13, j+8, j+2.
    always_comb begin
        j0    = cnt_q[3:0];
        j2    = j0 + 4'd2;
        j8    = j0 + 4'd8;
        j13   = j0 + 4'd13;
        w_mix = w_q[j13] ^ w_q[j8] ^ w_q[j2] ^ w_q[j0];
        w_t   = (cnt_q < 7'd16) ? w_q[j0] : {w_mix[30:0], w_mix[31]};
        if (cnt_q < 7'd20) begin
            f = (b_q & c_q) | (~b_q & d_q);
            k = 32'h5A82_7999;
        end else if (cnt_q < 7'd40) begin
            f = b_q ^ c_q ^ d_q;
            k = 32'h6ED9_EBA1;
        end else if (cnt_q < 7'd60) begin
            f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
            k = 32'h8F1B_BCDC;
        end else begin
            f = b_q ^ c_q ^ d_q;
            k = 32'hCA62_C1D6;
        end
        temp = {a_q[26:0], a_q[31:27]} + f + e_q + k + w_t;
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = acc;
        dat_o_d   = (acc && !wbs_we_i) ? rd_data : 32'h0;
        wr_pend_d = acc && wbs_we_i && (wbs_sel_i == 4'hF);
        wr_off_d  = acc ? off[5:0] : wr_off_q;
        wr_dat_d  = acc ? wbs_dat_i : wr_dat_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        w_d       = w_q;
        h_d       = h_q;
        a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; e_d = e_q;
        cnt_d     = cnt_q;

        // Writes are applied in the ack cycle, one clock after acceptance.
        push    = wr_pend_q && (wr_off_q == OFF_MSG);
        pop     = (state_q == ST_LOAD);
        push_ok = push && (!full || pop);
        if (push && !push_ok)
            ovf_d = 1'b1;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = wr_dat_q;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop)
            level_d = level_q + LVL_ONE;
        else if (!push_ok && pop)
            level_d = level_q - LVL_ONE;

        case (state_q)
            ST_LOAD: begin
                w_d[cnt_q[3:0]] = fifo_q[rd_ptr_q];
                rd_ptr_d        = rd_ptr_q + PTR_ONE;
                if (cnt_q == 7'd0) begin
                    a_d = h_q[0]; b_d = h_q[1]; c_d = h_q[2]; d_d = h_q[3]; e_d = h_q[4];
                end
                if (cnt_q == 7'd15) begin
                    cnt_d   = 7'd0;
                    state_d = ST_ROUND;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_ROUND: begin
                w_d[j0] = w_t;
                e_d = d_q;
                d_d = c_q;
                c_d = {b_q[1:0], b_q[31:2]};
                b_d = a_q;
                a_d = temp;
                if (cnt_q == 7'd79) begin
                    cnt_d   = 7'd0;
                    state_d = ST_UPDATE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_UPDATE: begin
                h_d[0]  = h_q[0] + a_q;
                h_d[1]  = h_q[1] + b_q;
                h_d[2]  = h_q[2] + c_q;
                h_d[3]  = h_q[3] + d_q;
                h_d[4]  = h_q[4] + e_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (wr_pend_q && (wr_off_q == OFF_IRQCLR)) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
        end

        if (wr_pend_q && (wr_off_q == OFF_CTRL)) begin
            if (wr_dat_q[2]) begin
                state_d  = ST_IDLE;
                irq_en_d = 1'b0;
                done_d   = 1'b0;
                ovf_d    = 1'b0;
                err_d    = 1'b0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                level_d  = '0;
                h_d      = IV;
                cnt_d    = 7'd0;
            end else begin
                irq_en_d = wr_dat_q[3];
                if (wr_dat_q[0] || wr_dat_q[1]) begin
                    if (is_busy || (level_q < LVL_BLOCK)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        cnt_d   = 7'd0;
                        done_d  = 1'b0;
                        if (wr_dat_q[0])
                            h_d = IV;
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            dat_o_q   <= '0;
            wr_pend_q <= 1'b0;
            wr_off_q  <= '0;
            wr_dat_q  <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            h_q       <= IV;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0; e_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
            wr_pend_q <= wr_pend_d;
            wr_off_q  <= wr_off_d;
            wr_dat_q  <= wr_dat_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            w_q       <= w_d;
            h_q       <= h_d;
            a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; e_q <= e_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign irq       = done_q && irq_en_q;
    assign busy      = is_busy;

endmodule
`default_nettype wire
